// File: rtl/button_conditioner.sv
// button_conditioner: N independent push-button channels. Each channel runs
// a synchroniser, a debounce counter that accepts a new level only after it
// has disagreed for DEBOUNCE_CYCLES consecutive cycles, and a hold FSM that
// produces press/release/long-press strobes plus optional auto-repeat.
// All outputs come straight from flops.
//
// The release strobe port is named `rel` because `release` is a reserved
// SystemVerilog keyword.
module button_conditioner #(
    parameter int N               = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic         clk,
    input  logic         rst,          // asynchronous, active-low
    input  logic [N-1:0] btn_in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] long_press
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW  = $clog2(LONG_CYCLES);
    localparam int RW  = $clog2(REPEAT_CYCLES);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [DBW-1:0]         db_cnt;
        logic                   lvl_q;
        logic                   accept;
        logic                   rise;
        logic                   fall;
        state_t                 state;
        logic [HW-1:0]          hold_cnt;
        logic [RW-1:0]          rep_cnt;
        logic                   press_q;
        logic                   rel_q;
        logic                   long_q;

        assign s = sync_q[SYNC_STAGES-1];

        // Shift the raw button through the synchroniser chain.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) sync_q <= '0;
            else      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[g]};
        end

        // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing
        // cycle; any agreeing cycle restarts the count.
        assign accept = (s != lvl_q) && (db_cnt == DB_LAST);
        assign rise   = accept && s;
        assign fall   = accept && !s;

        // Debounce counter and accepted level.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_cnt <= '0;
                lvl_q  <= 1'b0;
            end else if (s == lvl_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                lvl_q  <= s;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        // Hold FSM. The strobes are driven from the same edge that updates
        // the level, so press/release line up with the level change. A
        // release beats any long/repeat strobe due on the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                if (fall) begin
                    rel_q    <= 1'b1;
                    state    <= IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                press_q  <= 1'b1;
                                hold_cnt <= '0;
                                state    <= PRESSED;
                            end
                        end
                        PRESSED: begin
                            if (hold_cnt == LONG_LAST) begin
                                long_q  <= 1'b1;
                                rep_cnt <= '0;
                                state   <= HELD;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        HELD: begin
                            // Disabling repeat parks the counter at zero so a
                            // re-enable waits a full period.
                            if (!repeat_en[g]) begin
                                rep_cnt <= '0;
                            end else if (rep_cnt == REP_LAST) begin
                                press_q <= 1'b1;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign level[g]      = lvl_q;
        assign press[g]      = press_q;
        assign rel[g]        = rel_q;
        assign long_press[g] = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Expected strobe/level events are
// queued with their absolute cycle number when stimulus is applied and
// compared every cycle, one sample 1 ns after each rising edge.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int LC = 10;
    localparam int RC = 3;
    localparam int LAT = SS + DB;   // sample edge -> level/strobe edge offset

    localparam int K_UP = 0, K_DN = 1, K_PR = 2, K_RL = 3, K_LG = 4;

    typedef struct {
        int at;
        int ch;
        int kind;
    } ev_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] long_press;

    ev_t          q[$];
    logic [N-1:0] exp_lvl;
    int           cyc;
    int           checks;
    int           failures;

    button_conditioner #(
        .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .level(level), .press(press), .rel(rel), .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic ev(input int ch, input int kind, input int at);
        ev_t e;
        e.at = at; e.ch = ch; e.kind = kind;
        q.push_back(e);
    endtask

    // Button changed now: first sampled next edge, visible LAT edges later.
    task automatic rise(input int ch);
        ev(ch, K_UP, cyc + LAT);
        ev(ch, K_PR, cyc + LAT);
    endtask

    task automatic fall(input int ch);
        ev(ch, K_DN, cyc + LAT);
        ev(ch, K_RL, cyc + LAT);
    endtask

    // Advance one edge, then compare every output against the scoreboard.
    task automatic step();
        logic [N-1:0] ep, er, el;
        @(posedge clk);
        cyc++;
        #1;
        ep = '0; er = '0; el = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                case (q[i].kind)
                    K_UP:    exp_lvl[q[i].ch] = 1'b1;
                    K_DN:    exp_lvl[q[i].ch] = 1'b0;
                    K_PR:    ep[q[i].ch] = 1'b1;
                    K_RL:    er[q[i].ch] = 1'b1;
                    default: el[q[i].ch] = 1'b1;
                endcase
                q.delete(i);
            end
        end
        chk("level", level, exp_lvl);
        chk("press", press, ep);
        chk("release", rel, er);
        chk("long_press", long_press, el);
    endtask

    initial begin
        int c;
        checks = 0; failures = 0; cyc = 0; exp_lvl = '0;
        rst = 1'b0; btn_in = '0; repeat_en = '0;

        // Reset state
        #3;
        chk("rst_level", level, '0);
        chk("rst_press", press, '0);
        chk("rst_release", rel, '0);
        chk("rst_long", long_press, '0);
        @(posedge clk);
        #2 rst = 1'b1;

        // 1: basic press, 8 high samples, release
        btn_in[0] = 1'b1; rise(0);
        repeat (8) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (12) step();

        // 2: 3-cycle glitch, bounce, then a clean hold
        btn_in[0] = 1'b1;
        repeat (3) step();
        btn_in[0] = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            btn_in[0] = (i % 2 == 0);
            if (i == 4) rise(0);
            step();
        end
        repeat (7) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (12) step();

        // 3: long press, auto-repeat, pause and resume
        c = cyc;
        repeat_en[0] = 1'b1; btn_in[0] = 1'b1; rise(0);
        ev(0, K_LG, c + 16);
        ev(0, K_PR, c + 19);
        ev(0, K_PR, c + 22);
        while (cyc < c + 23) step();
        repeat_en[0] = 1'b0;
        while (cyc < c + 26) step();
        repeat_en[0] = 1'b1;
        ev(0, K_PR, c + 29);
        ev(0, K_PR, c + 32);
        ev(0, K_PR, c + 35);
        while (cyc < c + 30) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (10) step();
        repeat_en[0] = 1'b0;

        // 4a: long hold without repeat
        c = cyc;
        btn_in[0] = 1'b1; rise(0);
        ev(0, K_LG, c + 16);
        while (cyc < c + 30) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (10) step();

        // 4b: release lands on a repeat-due cycle
        c = cyc;
        repeat_en[0] = 1'b1; btn_in[0] = 1'b1; rise(0);
        ev(0, K_LG, c + 16);
        ev(0, K_PR, c + 19);
        ev(0, K_PR, c + 22);
        while (cyc < c + 19) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (10) step();
        repeat_en[0] = 1'b0;

        // 4c: release lands on the long-press cycle
        c = cyc;
        btn_in[0] = 1'b1; rise(0);
        while (cyc < c + 10) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (10) step();

        // 5: asynchronous reset while a repeat strobe is high
        c = cyc;
        repeat_en[0] = 1'b1; btn_in[0] = 1'b1; rise(0);
        ev(0, K_LG, c + 16);
        ev(0, K_PR, c + 19);
        while (cyc < c + 19) step();
        #2 rst = 1'b0;
        #1;
        chk("arst_level", level, '0);
        chk("arst_press", press, '0);
        chk("arst_release", rel, '0);
        chk("arst_long", long_press, '0);
        q.delete();
        exp_lvl = '0;
        #2 rst = 1'b1;
        rise(0);
        repeat (8) step();
        btn_in[0] = 1'b0; fall(0);
        repeat (10) step();
        repeat_en[0] = 1'b0;

        // 6: overlapping channels, ch0 repeating, ch1 not
        c = cyc;
        repeat_en = 2'b01;
        btn_in[0] = 1'b1; rise(0);
        ev(0, K_LG, c + 16);
        ev(0, K_PR, c + 19);
        ev(0, K_PR, c + 22);
        ev(0, K_PR, c + 25);
        repeat (3) step();
        btn_in[1] = 1'b1; rise(1);
        ev(1, K_LG, c + 19);
        while (cyc < c + 20) step();
        btn_in[0] = 1'b0; fall(0);
        while (cyc < c + 24) step();
        btn_in[1] = 1'b0; fall(1);
        repeat (12) step();

        // Every queued expectation must have been consumed
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL leftover_events got=%0d exp=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
